// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM access path.
// Used by the read-out engine, the RAM port mux and the loader, so that all
// of them agree on bus widths and on how the read-out state is encoded.
package mem_pkg;

   // Default RAM geometry: 64K entries of one byte each.
   localparam int ADDR_WIDTH_DEF = 16;
   localparam int DWIDTH_DEF     = 8;

   // Read-out engine state encoding. The port mux decodes these values
   // directly, so the numbering must not change.
   typedef enum logic [2:0] {
      RO_IDLE = 3'd0,
      RO_READ = 3'd1,
      RO_WAIT = 3'd2,
      RO_SEND = 3'd3,
      RO_FIN  = 3'd4
   } readout_state_t;

endpackage

// File: rtl/dmem_readout.sv
// Purpose: on start, streams RAM[base_addr .. base_addr+len-1] out as bytes.
// Latency: first byte valid 3 cycles after start; 3 cycles per byte when unstalled.
// Backpressure: holds tx_data/tx_valid stable in SEND until tx_ready; no loss.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 one-cycle request, only honoured while idle
//   base_addr, len        first address and byte count, captured on start
//   mem_addr, mem_we      RAM address (always the current address), write enable (0)
//   mem_dout              RAM read data, one cycle after mem_addr is sampled
//   tx_data, tx_valid     byte stream towards the UART transmitter
//   tx_ready              consumer accept
//   busy                  high whenever the engine is not idle
//   finished              one-cycle pulse after the last byte is accepted
module dmem_readout
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DWIDTH     = DWIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] len,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   input  logic [DWIDTH-1:0]     mem_dout,
   output logic [DWIDTH-1:0]     tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  finished
);

   readout_state_t        state, state_nxt;
   logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
   logic [ADDR_WIDTH-1:0] remaining, remaining_nxt;
   logic [DWIDTH-1:0]     tx_data_q, tx_data_nxt;
   logic                  tx_valid_q, tx_valid_nxt;
   logic                  handshake;

   assign handshake = tx_valid_q & tx_ready;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RO_IDLE;
         cur_addr   <= '0;
         remaining  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         cur_addr   <= cur_addr_nxt;
         remaining  <= remaining_nxt;
         tx_data_q  <= tx_data_nxt;
         tx_valid_q <= tx_valid_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and datapath update
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      cur_addr_nxt  = cur_addr;
      remaining_nxt = remaining;
      tx_data_nxt   = tx_data_q;
      tx_valid_nxt  = tx_valid_q;

      case (state)
         RO_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  // Empty transfer: report completion without touching RAM.
                  state_nxt = RO_FIN;
               end else begin
                  cur_addr_nxt  = base_addr;
                  remaining_nxt = len;
                  state_nxt     = RO_READ;
               end
            end
         end

         // RAM samples mem_addr at the end of this cycle.
         RO_READ: state_nxt = RO_WAIT;

         // mem_dout is valid now; capture it so the byte stays stable in SEND
         // regardless of what the RAM port does afterwards.
         RO_WAIT: begin
            tx_data_nxt  = mem_dout;
            tx_valid_nxt = 1'b1;
            state_nxt    = RO_SEND;
         end

         RO_SEND: begin
            if (handshake) begin
               tx_valid_nxt = 1'b0;
               if (remaining == ADDR_WIDTH'(1)) begin
                  state_nxt = RO_FIN;
               end else begin
                  remaining_nxt = remaining - 1'b1;
                  // Natural modulo wrap at the top of the address space.
                  cur_addr_nxt  = cur_addr + 1'b1;
                  state_nxt     = RO_READ;
               end
            end
         end

         RO_FIN: state_nxt = RO_IDLE;

         default: begin
            state_nxt    = RO_IDLE;
            tx_valid_nxt = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mem_addr = cur_addr;
   assign mem_we   = 1'b0;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = (state != RO_IDLE);
   assign finished = (state == RO_FIN);

endmodule

// File: tb/tb_dmem_readout.sv
// Directed bench for dmem_readout: table of transfers plus hand-written
// reset-abort sequences, with a behavioural synchronous-read RAM.
module tb_dmem_readout;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] len;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_dout;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        finished;

   always #5 clk = ~clk;

   // Synchronous-read RAM model.
   logic [7:0] ram [0:65535];
   always @(posedge clk) mem_dout <= ram[mem_addr];

   dmem_readout #(.ADDR_WIDTH(16), .DWIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_dout  (mem_dout),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .finished  (finished)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One transfer: base, len, cycles of tx_ready=0 at the first SEND,
   // two cycles at which a competing start (base 0x0200) is raised,
   // expected bytes (first byte in the top byte lane), expected finished cycle.
   typedef struct {
      logic [15:0] base;
      logic [15:0] len;
      int          stall;
      int          poke_a;
      int          poke_b;
      logic [31:0] bytes;
      int          fin;
   } vec_t;

   vec_t vecs [6];

   // Cycle 0 is the cycle in which start is high; outputs are sampled and
   // inputs driven at the falling edge of each cycle.
   task automatic run_vec(input int idx, input vec_t v);
      logic [7:0]  acc_dat  [8];
      int          acc_cyc  [8];
      logic [15:0] acc_addr [8];
      int          nacc = 0;
      int          nfin = 0;
      int          fin_cyc = -1;
      int          busy_first = -1;
      int          busy_last = -1;
      int          we_hits = 0;
      int          stab_err = 0;
      int          stall_left = v.stall;
      logic [7:0]  held = '0;
      bit          held_vld = 1'b0;
      bit          done = 1'b0;
      logic [15:0] exp_addr;

      @(negedge clk);
      chk($sformatf("v%0d busy_before_start", idx), {31'd0, busy}, 32'd0);
      start     = 1'b1;
      base_addr = v.base;
      len       = v.len;
      tx_ready  = 1'b1;

      for (int c = 1; c <= 300 && !done; c++) begin
         @(negedge clk);
         start = (c == v.poke_a) || (c == v.poke_b);
         if (start) begin
            base_addr = 16'h0200;
            len       = 16'd4;
         end
         if (mem_we) we_hits++;
         if (busy) begin
            if (busy_first < 0) busy_first = c;
            busy_last = c;
         end
         if (finished) begin
            nfin++;
            fin_cyc = c;
         end
         tx_ready = 1'b1;
         if (tx_valid) begin
            if (held_vld && tx_data !== held) stab_err++;
            if (stall_left > 0) begin
               tx_ready = 1'b0;
               stall_left--;
               held     = tx_data;
               held_vld = 1'b1;
            end else begin
               if (nacc < 8) begin
                  acc_dat[nacc]  = tx_data;
                  acc_cyc[nacc]  = c;
                  acc_addr[nacc] = mem_addr;
               end
               nacc++;
               held_vld = 1'b0;
            end
         end
         if (fin_cyc >= 0 && c >= fin_cyc + 4) done = 1'b1;
      end
      start = 1'b0;

      chk($sformatf("v%0d finished_cycle", idx), fin_cyc, v.fin);
      chk($sformatf("v%0d finished_pulses", idx), nfin, 32'd1);
      chk($sformatf("v%0d byte_count", idx), nacc, {16'd0, v.len});
      for (int k = 0; k < int'(v.len) && k < 8; k++) begin
         exp_addr = v.base + 16'(k);
         chk($sformatf("v%0d byte%0d_data", idx, k), {24'd0, acc_dat[k]},
             {24'd0, v.bytes[31-8*k -: 8]});
         chk($sformatf("v%0d byte%0d_cycle", idx, k), acc_cyc[k], 3 + 3*k + v.stall);
         chk($sformatf("v%0d byte%0d_addr", idx, k), {16'd0, acc_addr[k]}, {16'd0, exp_addr});
      end
      chk($sformatf("v%0d busy_first", idx), busy_first, 32'd1);
      chk($sformatf("v%0d busy_last", idx), busy_last, v.fin);
      chk($sformatf("v%0d mem_we_high", idx), we_hits, 32'd0);
      chk($sformatf("v%0d tx_data_unstable", idx), stab_err, 32'd0);
   endtask

   // Start a transfer, pull rst_n low during cycle rst_cyc, check the abort.
   task automatic reset_mid(input string name, input logic [15:0] b, input logic [15:0] l,
                            input int rst_cyc, input bit rdy, input bit exp_vld_pre);
      int nfin = 0;
      @(negedge clk);
      start     = 1'b1;
      base_addr = b;
      len       = l;
      tx_ready  = rdy;
      for (int c = 1; c <= rst_cyc; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (finished) nfin++;
         if (c == rst_cyc) begin
            chk({name, " busy_pre"}, {31'd0, busy}, 32'd1);
            chk({name, " tx_valid_pre"}, {31'd0, tx_valid}, {31'd0, exp_vld_pre});
            rst_n = 1'b0;
         end
      end
      @(negedge clk);
      if (finished) nfin++;
      chk({name, " tx_valid_after"}, {31'd0, tx_valid}, 32'd0);
      chk({name, " busy_after"}, {31'd0, busy}, 32'd0);
      chk({name, " mem_addr_after"}, {16'd0, mem_addr}, 32'd0);
      chk({name, " tx_data_after"}, {24'd0, tx_data}, 32'd0);
      chk({name, " finished_pulses"}, nfin, 32'd0);
      rst_n    = 1'b1;
      tx_ready = 1'b1;
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
      ram[16'h0010] = 8'hA1;
      ram[16'h0011] = 8'hB2;
      ram[16'h0012] = 8'hC3;
      ram[16'h0013] = 8'hD4;
      ram[16'hFFFE] = 8'h11;
      ram[16'hFFFF] = 8'h22;
      ram[16'h0000] = 8'h33;
      ram[16'h0200] = 8'h5A;
      ram[16'h0201] = 8'h6B;
      ram[16'h0202] = 8'h7C;
      ram[16'h0203] = 8'h8D;

      //          base      len    stall poke_a poke_b bytes         fin
      vecs[0] = '{16'h0010, 16'd4, 0,    -1,    -1,    32'hA1B2C3D4, 13}; // basic
      vecs[1] = '{16'h0010, 16'd4, 5,    -1,    -1,    32'hA1B2C3D4, 18}; // backpressure
      vecs[2] = '{16'hFFFE, 16'd3, 0,    -1,    -1,    32'h11223300, 10}; // address wrap
      vecs[3] = '{16'h0010, 16'd0, 0,    -1,    -1,    32'h00000000, 1};  // zero length
      vecs[4] = '{16'h0010, 16'd2, 0,    3,     7,     32'hA1B2_0000, 7}; // start in SEND and FIN
      vecs[5] = '{16'h0200, 16'd1, 0,    -1,    -1,    32'h5A000000, 4};  // single byte

      rst_n     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      len       = '0;
      tx_ready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("reset mem_we", {31'd0, mem_we}, 32'd0);
      chk("reset tx_data", {24'd0, tx_data}, 32'd0);
      chk("reset tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset finished", {31'd0, finished}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Abort while re-reading the third byte, then a fresh transfer.
      reset_mid("rst_read", 16'h0010, 16'd4, 7, 1'b1, 1'b0);
      run_vec(10, vecs[5]);

      // Abort while a stalled byte is pending on the stream.
      reset_mid("rst_send", 16'h0010, 16'd4, 5, 1'b0, 1'b1);
      run_vec(11, vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
